red_pitaya_asg_ch_v2: RTL and testbench

RED_PITAYA_ASG_CH_V2 -- requirements
Module: red_pitaya_asg_ch_v2

---
 rtl/red_pitaya_asg_ch_v2_if.sv | 12 +
 rtl/red_pitaya_asg_ch_v2.sv | 179 +++++++++++++++++
 tb/tb_red_pitaya_asg_ch_v2.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/red_pitaya_asg_ch_v2_if.sv
// red_pitaya_asg_ch_v2_if: waveform table write/readback bus between host and generator channel
interface red_pitaya_asg_ch_v2_if #(
  parameter int RSZ = 14,
  parameter int DW  = 14
);
  logic           buf_we_i;
  logic [RSZ-1:0] buf_addr_i;
  logic [DW-1:0]  buf_wdata_i;
  logic [DW-1:0]  buf_rdata_o;
  modport master (output buf_we_i, buf_addr_i, buf_wdata_i, input buf_rdata_o);
  modport slave (input buf_we_i, buf_addr_i, buf_wdata_i, output buf_rdata_o);
endinterface

// File: rtl/red_pitaya_asg_ch_v2.sv
// red_pitaya_asg_ch_v2: table-driven arbitrary signal generator channel; define ASG_INTERP_EN for linear interpolation between table entries
module red_pitaya_asg_ch_v2 #(
  parameter int RSZ = 14,
  parameter int DW  = 14,
  parameter int FW  = 32
) (
  input  logic                 dac_clk_i,
  input  logic                 dac_rst_i,
  input  logic                 trig_sw_i,
  input  logic                 trig_ext_i,
  input  logic [2:0]           trig_src_i,
  output logic                 trig_done_o,
  red_pitaya_asg_ch_v2_if.slave buf_if,
  output logic [RSZ-1:0]       buf_rpnt_o,
  input  logic [RSZ-1:0]       set_size_i,
  input  logic [RSZ+FW-1:0]    set_step_i,
  input  logic [RSZ-1:0]       set_ofs_i,
  input  logic                 set_rst_i,
  input  logic                 set_wrap_i,
  input  logic [DW-1:0]        set_amp_i,
  input  logic signed [DW-1:0] set_dc_i,
  input  logic [DW-1:0]        set_first_i,
  input  logic [DW-1:0]        set_last_i,
  input  logic                 set_zero_i,
  input  logic [15:0]          set_ncyc_i,
  input  logic [15:0]          set_rnum_i,
  input  logic [31:0]          set_rdly_i,
  output logic [DW-1:0]        dac_o,
  output logic                 busy_o
);
  localparam int PW = RSZ + FW;
`ifdef ASG_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam logic signed [DW+1:0] YMAX = (DW+2)'((1 << (DW - 1)) - 1);
  localparam logic signed [DW+1:0] YMIN = ~YMAX;
  typedef enum logic [1:0] {IDLE, RUN, DELAY, LAST} state_t;
  state_t state_q, state_d, fs;
  logic [PW-1:0] p_q, p_d, p_ofs, pw;
  logic [PW:0] pn, lim;
  logic [15:0] cyc_q, cyc_d, rep_q, rep_d;
  logic [31:0] dly_q, dly_d;
  logic trig_in_q, trig_d, done_d;
  logic [2:0] ext_q;
  logic [RSZ-1:0] rpnt_q, idx;
  logic [DW-1:0] mem [2**RSZ];
  logic [DW-1:0] rdata_q, dac_d, dac_q;
  logic signed [DW-1:0] s0_q, smp;
  logic signed [2*DW:0] prod;
  logic signed [DW+1:0] y_d, y_q;
  logic [2:0] fl_q [LAT-1];
  assign p_ofs = {set_ofs_i, {FW{1'b0}}};
  assign pn = {1'b0, p_q} + {1'b0, set_step_i};
  assign lim = {{1'b0, set_size_i} + (RSZ+1)'(1), {FW{1'b0}}};
  assign pw = pn[PW-1:0] - lim[PW-1:0];
  assign idx = p_q[PW-1:FW];
  assign trig_d = trig_src_i == 3'd1 ? trig_sw_i :
                  trig_src_i == 3'd2 ? ext_q[1] & ~ext_q[2] :
                  trig_src_i == 3'd3 ? ~ext_q[1] & ext_q[2] : 1'b0;
  // burst sequencing: trigger arm, pointer advance with wrap, cycle/repeat/delay counting
  always_comb begin
    state_d = state_q;
    p_d = p_q;
    cyc_d = cyc_q;
    rep_d = rep_q;
    dly_d = dly_q;
    done_d = 1'b0;
    if (set_rst_i) begin
      state_d = IDLE;
      p_d = p_ofs;
      cyc_d = '0;
      rep_d = '0;
      dly_d = '0;
    end else begin
      case (state_q)
        IDLE, LAST: if (trig_in_q) begin
          state_d = RUN;
          p_d = p_ofs;
          cyc_d = set_ncyc_i;
          rep_d = set_rnum_i;
          done_d = 1'b1;
        end
        RUN: if (pn >= lim) begin
          p_d = set_wrap_i ? pw : p_ofs;
          if (cyc_q != 16'd1) cyc_d = cyc_q == 16'd0 ? cyc_q : cyc_q - 16'd1;
          else if (rep_q == 16'd0) state_d = LAST;
          else begin
            state_d = DELAY;
            dly_d = set_rdly_i;
            rep_d = set_rnum_i == 16'hFFFF ? rep_q : rep_q - 16'd1;
          end
        end else p_d = pn[PW-1:0];
        DELAY: if (dly_q == 32'd0) begin
          state_d = RUN;
          p_d = p_ofs;
          cyc_d = set_ncyc_i;
        end else dly_d = dly_q - 32'd1;
        default: state_d = IDLE;
      endcase
    end
  end
  // control registers, external trigger synchroniser and pointer readout
  always_ff @(posedge dac_clk_i)
    if (dac_rst_i) begin
      state_q <= IDLE;
      p_q <= '0;
      cyc_q <= '0;
      rep_q <= '0;
      dly_q <= '0;
      trig_in_q <= 1'b0;
      ext_q <= '0;
      rpnt_q <= '0;
    end else begin
      state_q <= state_d;
      p_q <= p_d;
      cyc_q <= cyc_d;
      rep_q <= rep_d;
      dly_q <= dly_d;
      trig_in_q <= trig_d;
      ext_q <= {ext_q[1:0], trig_ext_i};
      rpnt_q <= idx;
    end
  // host write and readback; playback reading the same word in the write cycle sees the old value
  always_ff @(posedge dac_clk_i) begin
    if (buf_if.buf_we_i) mem[buf_if.buf_addr_i] <= buf_if.buf_wdata_i;
    rdata_q <= mem[buf_if.buf_addr_i];
  end
`ifdef ASG_INTERP_EN
  logic signed [DW-1:0] s1_q, smp_q;
  logic [15:0] fr_q;
  logic [RSZ-1:0] idx1;
  logic signed [DW:0] dif;
  logic signed [DW+17:0] ip;
  assign idx1 = idx == set_size_i ? set_ofs_i : idx + RSZ'(1);
  assign dif = (DW+1)'(s1_q) - (DW+1)'(s0_q);
  assign ip = (DW+18)'(dif) * (DW+18)'($signed({1'b0, fr_q}));
  // neighbour tap plus fraction, then the interpolated sample
  always_ff @(posedge dac_clk_i)
    if (dac_rst_i) begin
      s1_q <= '0;
      fr_q <= '0;
      smp_q <= '0;
    end else begin
      s1_q <= mem[idx1];
      fr_q <= p_q[FW-1:FW-16];
      smp_q <= s0_q + DW'(ip >>> 16);
    end
  assign smp = smp_q;
`else
  assign smp = s0_q;
`endif
  assign prod = (2*DW+1)'(smp) * (2*DW+1)'($signed({1'b0, set_amp_i}));
  assign y_d = (DW+2)'(prod >>> (DW - 1)) + (DW+2)'(set_dc_i);
  assign fs = state_t'(fl_q[LAT-2][1:0]);
  assign dac_d = fl_q[LAT-2][2] ? '0 :
                 fs == RUN ? (y_q > YMAX ? YMAX[DW-1:0] : y_q < YMIN ? YMIN[DW-1:0] : y_q[DW-1:0]) :
                 fs == IDLE ? set_first_i : set_last_i;
  // sample pipeline: table read, gain+offset (kept two bits wide for headroom), saturate+select; flags ride alongside
  always_ff @(posedge dac_clk_i)
    if (dac_rst_i) begin
      s0_q <= '0;
      y_q <= '0;
      dac_q <= '0;
      for (int k = 0; k < LAT - 1; k++) fl_q[k] <= '0;
    end else begin
      s0_q <= mem[idx];
      y_q <= y_d;
      dac_q <= dac_d;
      fl_q[0] <= {set_zero_i, state_q};
      for (int k = 1; k < LAT - 1; k++) fl_q[k] <= fl_q[k-1];
    end
  assign trig_done_o = done_d;
  assign busy_o = state_q == RUN || state_q == DELAY;
  assign buf_rpnt_o = rpnt_q;
  assign buf_if.buf_rdata_o = rdata_q;
  assign dac_o = dac_q;
endmodule

// File: tb/tb_red_pitaya_asg_ch_v2.sv
// tb_red_pitaya_asg_ch_v2: scoreboard bench; expectations queued per due cycle, monitor compares each cycle
module tb_red_pitaya_asg_ch_v2;
  localparam int RSZ = 14, DW = 14, FW = 32;
`ifdef ASG_INTERP_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif
  localparam int DAC = 0, BUSY = 1, DONE = 2, RPNT = 3, RDATA = 4;
  localparam int FIRST = 11, LASTV = 22;
  typedef struct {int at; int sig; int val; string name;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic trig_sw = 1'b0, trig_ext = 1'b0, trig_done;
  logic [2:0] trig_src = 3'd1;
  logic [RSZ-1:0] rpnt, size = '0, ofs = '0;
  logic [RSZ+FW-1:0] step = '0;
  logic set_rst = 1'b0, wrap = 1'b1, zero = 1'b0, busy;
  logic [DW-1:0] amp = 14'd8192, dc = '0, first = DW'(FIRST), last = DW'(LASTV), dac;
  logic [15:0] ncyc = '0, rnum = '0;
  logic [31:0] rdly = '0;
  int cnt = 0, checks = 0, passes = 0;
  exp_t sb[$];
  red_pitaya_asg_ch_v2_if #(.RSZ(RSZ), .DW(DW)) bif ();
  red_pitaya_asg_ch_v2 #(.RSZ(RSZ), .DW(DW), .FW(FW)) dut (
    .dac_clk_i(clk), .dac_rst_i(rst), .trig_sw_i(trig_sw), .trig_ext_i(trig_ext),
    .trig_src_i(trig_src), .trig_done_o(trig_done), .buf_if(bif), .buf_rpnt_o(rpnt),
    .set_size_i(size), .set_step_i(step), .set_ofs_i(ofs), .set_rst_i(set_rst),
    .set_wrap_i(wrap), .set_amp_i(amp), .set_dc_i(dc), .set_first_i(first),
    .set_last_i(last), .set_zero_i(zero), .set_ncyc_i(ncyc), .set_rnum_i(rnum),
    .set_rdly_i(rdly), .dac_o(dac), .busy_o(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;
  function automatic int act_of(input int s);
    return s == DAC ? int'($signed(dac)) : s == BUSY ? int'(busy) : s == DONE ? int'(trig_done) :
           s == RPNT ? int'(rpnt) : int'(bif.buf_rdata_o);
  endfunction
  task automatic want(input int dt, input int sig, input int val, input string name);
    exp_t e;
    int i;
    e = '{cnt + dt, sig, val, name};
    i = 0;
    while (i < sb.size() && sb[i].at <= e.at) i++;
    sb.insert(i, e);
  endtask
  always begin
    @(negedge clk);
    #1;
    while (sb.size() > 0 && sb[0].at <= cnt) begin : pop
      exp_t e;
      int act;
      e = sb.pop_front();
      act = act_of(e.sig);
      checks++;
      if (e.at == cnt && act == e.val) passes++;
      else $display("FAIL %s cycle %0d: got %0d, expected %0d (due cycle %0d)", e.name, cnt, act, e.val, e.at);
    end
  end
  task automatic drain();
    for (int i = 0; i < 400 && sb.size() > 0; i++) @(negedge clk);
    while (sb.size() > 0) begin : lost
      exp_t e;
      e = sb.pop_front();
      checks++;
      $display("FAIL %s: no comparison by timeout, expected %0d", e.name, e.val);
    end
  endtask
  task automatic wr(input int a, input int d);
    bif.buf_we_i = 1'b1;
    bif.buf_addr_i = RSZ'(a);
    bif.buf_wdata_i = DW'(d);
    @(negedge clk);
    bif.buf_we_i = 1'b0;
  endtask
  task automatic pulse_sw();
    trig_src = 3'd1;
    trig_sw = 1'b1;
    @(negedge clk);
    trig_sw = 1'b0;
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end
  initial begin
    bif.buf_we_i = 1'b0;
    bif.buf_addr_i = '0;
    bif.buf_wdata_i = '0;
    repeat (2) @(negedge clk);
    want(1, DAC, 0, "rst_dac");
    want(1, BUSY, 0, "rst_busy");
    want(1, DONE, 0, "rst_done");
    want(1, RPNT, 0, "rst_rpnt");
    @(negedge clk);
    rst = 1'b0;
    want(LAT, DAC, FIRST, "idle_first");
    for (int k = 0; k < 5; k++) wr(k, k == 4 ? 77 : k);
    bif.buf_addr_i = 2;
    want(1, RDATA, 2, "readback");
    drain();
    size = 3;
    step[FW] = 1'b1;
    ncyc = 2;
    rnum = 0;
    want(1, DONE, 1, "done_pulse");
    want(2, DONE, 0, "done_once");
    want(2, BUSY, 1, "busy_run");
    want(9, BUSY, 1, "busy_end");
    want(10, BUSY, 0, "busy_last");
    want(4, RPNT, 1, "rpnt1");
    want(6, RPNT, 3, "rpnt3");
    want(1 + LAT, DAC, FIRST, "pre_burst");
    for (int j = 0; j < 8; j++) want(2 + LAT + j, DAC, j % 4, $sformatf("burst%0d", j));
    want(10 + LAT, DAC, LASTV, "hold_last");
    pulse_sw();
    drain();
    ncyc = 1;
    rnum = 2;
    rdly = 5;
    for (int d = 1; d <= 27; d++) begin
      want(d, BUSY, int'(d >= 2 && d <= 25), $sformatf("rep_busy%0d", d));
      want(d, DONE, int'(d == 1), $sformatf("rep_done%0d", d));
    end
    for (int d = 2; d <= 26; d++)
      want(d + LAT, DAC, (d < 26 && (d - 2) % 10 < 4) ? (d - 2) % 10 : LASTV, $sformatf("rep_dac%0d", d));
    pulse_sw();
    repeat (5) @(negedge clk);
    pulse_sw();
    drain();
    rnum = 0;
    trig_src = 3'd2;
    want(2, DONE, 0, "ext_early");
    want(3, DONE, 1, "ext_rise");
    want(4, BUSY, 1, "ext_busy");
    trig_ext = 1'b1;
    drain();
    repeat (6) @(negedge clk);
    trig_src = 3'd3;
    @(negedge clk);
    want(2, DONE, 0, "fall_early");
    want(3, DONE, 1, "ext_fall");
    trig_ext = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    want(1, DONE, 0, "rst_trig_done");
    want(2, BUSY, 0, "rst_trig_busy");
    want(3, BUSY, 0, "rst_trig_idle");
    want(1 + LAT, DAC, LASTV, "rst_trig_was_last");
    want(2 + LAT, DAC, FIRST, "rst_trig_first");
    trig_src = 3'd1;
    trig_sw = 1'b1;
    @(negedge clk);
    trig_sw = 1'b0;
    set_rst = 1'b1;
    @(negedge clk);
    set_rst = 1'b0;
    drain();
    wr(0, 8191);
    size = 0;
    ncyc = 0;
    dc = 14'd100;
    want(2 + LAT, DAC, 8191, "sat_hi");
    want(5 + LAT, DAC, 8191, "sat_hold");
    want(20, BUSY, 1, "infinite");
    pulse_sw();
    drain();
    amp = 14'd4096;
    dc = '0;
    wr(0, -1000);
    want(LAT + 3, DAC, -500, "gain_half");
    drain();
    zero = 1'b1;
    want(1, BUSY, 1, "zero_busy");
    want(LAT + 1, DAC, 0, "zero_out");
    @(negedge clk);
    drain();
    zero = 1'b0;
    set_rst = 1'b1;
    want(1, BUSY, 0, "setrst_idle");
    want(LAT + 1, DAC, FIRST, "setrst_first");
    @(negedge clk);
    set_rst = 1'b0;
    drain();
    size = 3;
    amp = 14'd8192;
    pulse_sw();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    want(1, DAC, 0, "arst_dac");
    want(1, BUSY, 0, "arst_busy");
    want(1, RPNT, 0, "arst_rpnt");
    @(negedge clk);
    rst = 1'b0;
    bif.buf_addr_i = 1;
    want(1, RDATA, 1, "table_kept");
    want(3, DAC, FIRST, "arst_first");
    want(3, BUSY, 0, "arst_idle");
    drain();
`ifdef ASG_INTERP_EN
    wr(0, 0);
    wr(1, 1000);
    wr(2, 2000);
    step = '0;
    step[FW-2] = 1'b1;
    ncyc = 1;
    rnum = 0;
    for (int j = 0; j < 5; j++) want(2 + LAT + j, DAC, 250 * j, $sformatf("interp%0d", j));
    pulse_sw();
    drain();
`endif
    if (passes == 0) $display("FAIL no_pass: got %0d passes, expected more than 0", passes);
    if (passes == checks && checks >= 12) $display("PASS %0d/%0d checks passed", passes, checks);
    else $display("FAIL %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
